ahb_arbiter: RTL and testbench

Round-robin bus arbiter for the AHB memory subsystem. It shares the single AHB memory slave between up to `NUM_MASTERS` requesting masters. It watches the shared transfer-control signals so that fixed-length bursts and locked sequences are never broken. It drives the grant vector, address-phase and data-phase owner indices, and `hmastlock` for the downstream address/data multiplexers.

---
 rtl/ahb_arb_pkg.sv | 42 ++++
 rtl/ahb_arb_picker.sv | 63 ++++++
 rtl/ahb_arbiter.sv | 127 ++++++++++++
 tb/tb_ahb_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg
// Shared AHB encodings and helpers for the memory-subsystem bus arbiter.
// Holds the HTRANS and HBURST encodings and burst_len(), which maps a burst
// type onto its beat count. INCR is treated as a run of single beats.
// Configuration macro used by the arbiter: AHB_ARB_FIXED_PRIO_EN.

package ahb_arb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  localparam int BurstCntW = 5;

  // Undefined-length INCR bursts count as one beat so the owner can be
  // pre-empted after any accepted transfer.
  function automatic logic [BurstCntW-1:0] burst_len(input logic [2:0] hburst);
    logic [BurstCntW-1:0] len;
    case (hburst)
      HBURST_WRAP4, HBURST_INCR4:   len = 5'd4;
      HBURST_WRAP8, HBURST_INCR8:   len = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: len = 5'd16;
      default:                      len = 5'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ahb_arb_picker.sv
// ahb_arb_picker
// Combinational priority encoder that chooses the next bus owner.
// Ports:
//   req   - per-master request vector
//   last  - index of the most recently granted master
//   valid - at least one request is present
//   idx   - index of the chosen master (0 when valid is low)
// Default build: round-robin, scanning upward from last+1 with wrap-around.
// With AHB_ARB_FIXED_PRIO_EN defined: lowest requesting index wins and
// last is ignored.

module ahb_arb_picker #(
  parameter int NUM_MASTERS = 4,
  parameter int MW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [MW-1:0]          last,
  output logic                   valid,
  output logic [MW-1:0]          idx
);

`ifdef AHB_ARB_FIXED_PRIO_EN

  logic unusedLast;
  assign unusedLast = ^last;

  // Fixed priority: the first requester found from index 0 upward wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!valid && req[k]) begin
        valid = 1'b1;
        idx   = MW'(k);
      end
    end
  end

`else

  // Round-robin: the first pass looks at indices above last, the second
  // pass wraps around to indices at or below last. The combined order is
  // last+1, last+2, ... modulo NUM_MASTERS, so the previous owner comes last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!valid && req[k] && (k > int'(last))) begin
        valid = 1'b1;
        idx   = MW'(k);
      end
    end
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!valid && req[k] && (k <= int'(last))) begin
        valid = 1'b1;
        idx   = MW'(k);
      end
    end
  end

`endif

endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter
// Bus arbiter that shares one AHB memory slave between NUM_MASTERS masters.
// It never breaks fixed-length bursts or locked sequences.
// Ports:
//   hclk, hreset  - bus clock, asynchronous active-high reset
//   hbusreq/hlock - per-master request and lock request
//   htrans/hburst - shared transfer type and burst type (address-phase owner)
//   hready/hresp  - shared transfer-done signal and slave error response
//   hgrant        - one-hot grant
//   hmaster       - address-phase owner index
//   hmaster_data  - data-phase owner index (lags hmaster by one hready cycle)
//   hmastlock     - the current address phase is locked
// All outputs are registered.
// Configuration macro: AHB_ARB_FIXED_PRIO_EN selects fixed priority in the
// picker. The default build uses round-robin.

module ahb_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int MW          = $clog2(NUM_MASTERS)
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  input  logic                   hresp,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MW-1:0]          hmaster,
  output logic [MW-1:0]          hmaster_data,
  output logic                   hmastlock
);

  logic [BurstCntW-1:0]   burstCnt_q, burstCnt_d;
  logic [MW-1:0]          last_q, last_d;
  logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
  logic [MW-1:0]          hmaster_q, hmaster_d;
  logic [MW-1:0]          hmasterData_q, hmasterData_d;
  logic                   hmastlock_q, hmastlock_d;

  logic          accepted;
  logic          lockHolds;
  logic          rearb;
  logic          pickValid;
  logic [MW-1:0] pickIdx;

  ahb_arb_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .MW         (MW)
  ) u_picker (
    .req  (hbusreq),
    .last (last_q),
    .valid(pickValid),
    .idx  (pickIdx)
  );

  // Beat counter: loads the remaining beat count on an accepted NONSEQ and
  // counts down on accepted SEQ beats. An ERROR response during a wait state
  // clears it, so the bus is re-arbitrated at the next hready.
  always_comb begin
    accepted   = hready && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    burstCnt_d = burstCnt_q;
    if (hresp && !hready) begin
      burstCnt_d = '0;
    end else if (accepted && (htrans == HTRANS_NONSEQ)) begin
      burstCnt_d = burst_len(hburst) - 5'd1;
    end else if (accepted && (burstCnt_q != '0)) begin
      burstCnt_d = burstCnt_q - 5'd1;
    end
  end

  // Re-arbitration qualification and next owner. The decision uses the
  // counter value after this edge, so the grant moves exactly on the edge
  // that accepts the final beat. With no requester the bus parks on
  // master 0 and last is left alone.
  always_comb begin
    lockHolds     = hlock[hmaster_q] && hbusreq[hmaster_q];
    rearb         = hready && (burstCnt_d == '0) && !lockHolds;
    hgrant_d      = hgrant_q;
    hmaster_d     = hmaster_q;
    hmastlock_d   = hmastlock_q;
    last_d        = last_q;
    hmasterData_d = hready ? hmaster_q : hmasterData_q;
    if (rearb) begin
      hgrant_d = '0;
      if (pickValid) begin
        hgrant_d[pickIdx] = 1'b1;
        hmaster_d         = pickIdx;
        hmastlock_d       = hlock[pickIdx] && hbusreq[pickIdx];
        last_d            = pickIdx;
      end else begin
        hgrant_d[0] = 1'b1;
        hmaster_d   = '0;
        hmastlock_d = 1'b0;
      end
    end
  end

  // State registers. Reset parks the bus on master 0 and discards any burst
  // or lock in progress.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      burstCnt_q    <= '0;
      last_q        <= '0;
      hgrant_q      <= NUM_MASTERS'(1);
      hmaster_q     <= '0;
      hmasterData_q <= '0;
      hmastlock_q   <= 1'b0;
    end else begin
      burstCnt_q    <= burstCnt_d;
      last_q        <= last_d;
      hgrant_q      <= hgrant_d;
      hmaster_q     <= hmaster_d;
      hmasterData_q <= hmasterData_d;
      hmastlock_q   <= hmastlock_d;
    end
  end

  assign hgrant       = hgrant_q;
  assign hmaster      = hmaster_q;
  assign hmaster_data = hmasterData_q;
  assign hmastlock    = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter
// Directed testbench for ahb_arbiter with four masters. Each vector is
// applied just after a rising edge. The outputs are checked 1 time unit
// after the following rising edge against hand-computed values.
// Covers both builds: the last scenario checks fixed priority when
// AHB_ARB_FIXED_PRIO_EN is defined, and round-robin otherwise.

module tb_ahb_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] WRAP4  = 3'b010;
  localparam logic [2:0] INCR8  = 3'b101;
  localparam logic [2:0] INCR16 = 3'b111;

  logic       hclk;
  logic       hreset;
  logic [3:0] hbusreq;
  logic [3:0] hlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic       hresp;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic [1:0] hmaster_data;
  logic       hmastlock;

  int testsRun  = 0;
  int failCount = 0;

  ahb_arbiter #(
    .NUM_MASTERS(4),
    .MW         (2)
  ) dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .hbusreq     (hbusreq),
    .hlock       (hlock),
    .htrans      (htrans),
    .hburst      (hburst),
    .hready      (hready),
    .hresp       (hresp),
    .hgrant      (hgrant),
    .hmaster     (hmaster),
    .hmaster_data(hmaster_data),
    .hmastlock   (hmastlock)
  );

  // Free-running bus clock, period 10.
  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of bus inputs and returns 1 unit after the next edge.
  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] lck,
                               input logic [1:0] trans, input logic [2:0] burst,
                               input logic rdy, input logic resp);
    hbusreq = req;
    hlock   = lck;
    htrans  = trans;
    hburst  = burst;
    hready  = rdy;
    hresp   = resp;
    @(posedge hclk);
    #1;
  endtask

  // Short reset pulse aligned to an edge. Inputs are idle while it runs.
  task automatic pulseReset();
    hreset  = 1'b1;
    hbusreq = '0;
    hlock   = '0;
    htrans  = IDLE;
    hburst  = SINGLE;
    hready  = 1'b1;
    hresp   = 1'b0;
    @(posedge hclk);
    #1;
    hreset = 1'b0;
  endtask

  logic [3:0] expGrant [4];
  logic [1:0] expMaster[4];
  logic [1:0] expData  [4];

  initial begin
    hreset  = 1'b1;
    hbusreq = '0;
    hlock   = '0;
    htrans  = IDLE;
    hburst  = SINGLE;
    hready  = 1'b1;
    hresp   = 1'b0;

    // Reset and parking
    repeat (2) @(posedge hclk);
    #1;
    checkOutput("rst_grant",  hgrant,       4'b0001);
    checkOutput("rst_master", hmaster,      2'd0);
    checkOutput("rst_data",   hmaster_data, 2'd0);
    checkOutput("rst_lock",   hmastlock,    1'b0);
    hreset = 1'b0;
    applyStimulus(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
    checkOutput("park_grant",  hgrant,    4'b0001);
    checkOutput("park_master", hmaster,   2'd0);
    checkOutput("park_lock",   hmastlock, 1'b0);

    // Simultaneous requests rotate one grant per cycle
    pulseReset();
    expGrant  = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};
    expMaster = '{2'd1, 2'd2, 2'd3, 2'd1};
    expData   = '{2'd0, 2'd1, 2'd2, 2'd3};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b1110, 4'b0000, NONSEQ, SINGLE, 1'b1, 1'b0);
      checkOutput($sformatf("rr_grant%0d", i),  hgrant,       expGrant[i]);
      checkOutput($sformatf("rr_master%0d", i), hmaster,      expMaster[i]);
      checkOutput($sformatf("rr_data%0d", i),   hmaster_data, expData[i]);
    end

    // INCR8 burst from master 2 with three wait states mid-burst
    pulseReset();
    applyStimulus(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
    checkOutput("b8_own", hgrant, 4'b0100);
    applyStimulus(4'b0110, 4'b0000, NONSEQ, INCR8, 1'b1, 1'b0);
    checkOutput("b8_beat1", hgrant, 4'b0100);
    for (int b = 2; b <= 4; b++) begin
      applyStimulus(4'b0110, 4'b0000, SEQ, INCR8, 1'b1, 1'b0);
      checkOutput($sformatf("b8_beat%0d", b), hgrant, 4'b0100);
    end
    for (int w = 0; w < 3; w++) begin
      applyStimulus(4'b0110, 4'b0000, SEQ, INCR8, 1'b0, 1'b0);
      checkOutput($sformatf("b8_wait%0d", w),      hgrant,       4'b0100);
      checkOutput($sformatf("b8_wait_data%0d", w), hmaster_data, 2'd2);
    end
    for (int b = 5; b <= 7; b++) begin
      applyStimulus(4'b0110, 4'b0000, SEQ, INCR8, 1'b1, 1'b0);
      checkOutput($sformatf("b8_beat%0d", b), hgrant, 4'b0100);
    end
    applyStimulus(4'b0110, 4'b0000, SEQ, INCR8, 1'b1, 1'b0);
    checkOutput("b8_end_grant",  hgrant,       4'b0010);
    checkOutput("b8_end_master", hmaster,      2'd1);
    checkOutput("b8_end_data",   hmaster_data, 2'd2);
    applyStimulus(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
    checkOutput("b8_data_lag", hmaster_data, 2'd1);

    // Locked sequence from master 3 while master 0 waits
    pulseReset();
    applyStimulus(4'b1001, 4'b1000, IDLE, SINGLE, 1'b1, 1'b0);
    checkOutput("lk_grant", hgrant,    4'b1000);
    checkOutput("lk_lock",  hmastlock, 1'b1);
    for (int s = 0; s < 3; s++) begin
      applyStimulus(4'b1001, 4'b1000, NONSEQ, SINGLE, 1'b1, 1'b0);
      checkOutput($sformatf("lk_hold_grant%0d", s), hgrant,    4'b1000);
      checkOutput($sformatf("lk_hold_lock%0d", s),  hmastlock, 1'b1);
    end
    applyStimulus(4'b1001, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
    checkOutput("lk_rel_grant",  hgrant,    4'b0001);
    checkOutput("lk_rel_master", hmaster,   2'd0);
    checkOutput("lk_rel_lock",   hmastlock, 1'b0);

    // ERROR response during WRAP4 beat 2
    pulseReset();
    applyStimulus(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
    applyStimulus(4'b0110, 4'b0000, NONSEQ, WRAP4, 1'b1, 1'b0);
    checkOutput("er_beat1", hgrant, 4'b0100);
    applyStimulus(4'b0110, 4'b0000, SEQ, WRAP4, 1'b1, 1'b0);
    checkOutput("er_beat2", hgrant, 4'b0100);
    applyStimulus(4'b0110, 4'b0000, SEQ, WRAP4, 1'b0, 1'b1);
    checkOutput("er_wait", hgrant, 4'b0100);
    applyStimulus(4'b0110, 4'b0000, IDLE, WRAP4, 1'b1, 1'b0);
    checkOutput("er_grant",  hgrant,  4'b0010);
    checkOutput("er_master", hmaster, 2'd1);

    // Asynchronous reset during beat 5 of INCR16
    pulseReset();
    applyStimulus(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
    applyStimulus(4'b0100, 4'b0000, NONSEQ, INCR16, 1'b1, 1'b0);
    for (int b = 2; b <= 5; b++) begin
      applyStimulus(4'b0110, 4'b0000, SEQ, INCR16, 1'b1, 1'b0);
    end
    checkOutput("mr_pre_grant", hgrant, 4'b0100);
    hreset = 1'b1;
    #1;
    checkOutput("mr_grant",  hgrant,       4'b0001);
    checkOutput("mr_master", hmaster,      2'd0);
    checkOutput("mr_data",   hmaster_data, 2'd0);
    checkOutput("mr_lock",   hmastlock,    1'b0);
    #1;
    hreset = 1'b0;
    applyStimulus(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
    checkOutput("mr_park", hgrant, 4'b0001);
    applyStimulus(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
    checkOutput("mr_cnt_cleared", hgrant, 4'b0010);

    // Requests from masters 1 and 3 with single beats
    pulseReset();
`ifdef AHB_ARB_FIXED_PRIO_EN
    expGrant = '{4'b0010, 4'b0010, 4'b0010, 4'b0010};
`else
    expGrant = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
`endif
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b1010, 4'b0000, NONSEQ, SINGLE, 1'b1, 1'b0);
      checkOutput($sformatf("pr_grant%0d", i), hgrant, expGrant[i]);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
